conv_stream_top: RTL and testbench
==================================

CONV_STREAM_TOP -- requirements
Module: conv_stream_top

Interface
REQ-001 SHALL have parameter DATA_W, default 8: signed two's-complement width of ifmap, filter and output beats.
REQ-002 SHALL have parameter K, default 3, legal 2..7: kernel side; window holds N = K*K elements.
REQ-003 SHALL derive localparams ACC_W = 2*DATA_W + clog2(N) (20 at defaults) and NBEAT = ceil(ACC_W/DATA_W) (3 at defaults).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  begin one window job; sampled only in IDLE.
REQ-007 keep_filter  in  1  sampled with start; reuse stored filter, skip filter load.
REQ-008 ifm_valid / ifm_data / ifm_ready  in / in DATA_W / out  ifmap stream, N beats per job, row-major.
REQ-009 flt_valid / flt_data / flt_ready  in / in DATA_W / out  filter stream, N beats per load, row-major.
REQ-010 out_valid / out_data / out_last / out_ready  out / out DATA_W / out / in  result stream, NBEAT beats, LSB-first.
REQ-011 busy  out  1  high whenever state is not IDLE.
REQ-012 done  out  1  one-cycle pulse when the final output beat transfers.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD_IFM, LOAD_FLT, MAC, OUT.
REQ-014 IDLE -> LOAD_IFM on start=1; start in any other state is ignored.
REQ-015 Any stream transfers only on the cycle where valid and ready are both 1; data is captured on that edge.
REQ-016 ifm_ready = 1 only in LOAD_IFM; after beat N-1 transfers: -> MAC if reuse active, else -> LOAD_FLT.
REQ-017 Reuse is active only if keep_filter=1 at start AND a complete filter has been loaded since reset; otherwise keep_filter is ignored.
REQ-018 flt_ready = 1 only in LOAD_FLT; after beat N-1 transfers: set filter-loaded flag, -> MAC.
REQ-019 A partially loaded filter (job aborted by reset) SHALL leave the filter-loaded flag clear.
REQ-020 MAC: accumulator cleared on entry, one signed DATA_W x DATA_W product added per cycle, exactly N cycles, then -> OUT.
REQ-021 Accumulator is ACC_W signed; no overflow is possible within N terms.
REQ-022 OUT: result sign-extended to NBEAT*DATA_W, beat i = bits [i*DATA_W +: DATA_W], out_valid=1 throughout.
REQ-023 out_data and out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 out_last = 1 on beat NBEAT-1 only; on its transfer: done=1 for that cycle, -> IDLE.
REQ-025 start in the same cycle as done SHALL be ignored; the next job starts on a start seen in IDLE.
REQ-026 Latency, zero back-pressure, full load: N + N + N + NBEAT cycles from first ifmap transfer to done.

Reset
REQ-027 rst=0 SHALL immediately force IDLE, clear counters, accumulator and filter-loaded flag.
REQ-028 Reset values: ifm_ready=0, flt_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0.
REQ-029 Reset in any state, mid-transfer, SHALL abort the job with no output beat and no done pulse.

Configuration
REQ-030 Macro CONV_RELU_EN defined: result clamped to 0 when negative before serialisation; non-negative results unchanged.
REQ-031 Macro CONV_RELU_EN undefined: raw signed accumulator value is serialised.

Verification (K=3, DATA_W=8)
REQ-032 ifmap all 1, filter all 2 -> beats 0x12, 0x00, 0x00 (last on third), done one cycle after final transfer.
REQ-033 ifmap all -128, filter all 127 -> beats 0x80, 0xC4, 0xFD; with CONV_RELU_EN -> 0x00, 0x00, 0x00.
REQ-034 After REQ-032, start with keep_filter=1 and ifmap all 3 -> flt_ready never asserts, beats 0x36, 0x00, 0x00.
REQ-035 keep_filter=1 on first job after reset -> full filter load occurs (flt_ready asserts for 9 beats).
REQ-036 out_ready held 0 for 5 cycles on beat 1 -> out_data/out_last unchanged; no beat lost or duplicated.
REQ-037 rst pulsed low after 4 filter beats -> all outputs at reset values; next keep_filter=1 job performs full filter load.

Source files
------------

// File: rtl/conv_stream_if.sv
// Handshake streams of conv_stream_top: ifmap in, filter in, serialised result out.
interface conv_stream_if #(parameter int DATA_W = 8);
  logic              ifm_valid, ifm_ready;
  logic [DATA_W-1:0] ifm_data;
  logic              flt_valid, flt_ready;
  logic [DATA_W-1:0] flt_data;
  logic              out_valid, out_ready, out_last;
  logic [DATA_W-1:0] out_data;

  modport master (output ifm_valid, ifm_data, flt_valid, flt_data, out_ready,
                  input  ifm_ready, flt_ready, out_valid, out_data, out_last);
  modport slave  (input  ifm_valid, ifm_data, flt_valid, flt_data, out_ready,
                  output ifm_ready, flt_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/conv_stream_top.sv
// Single-window KxK signed convolution: stream in ifmap (+ optional filter), MAC, stream result LSB-first.
// Optional build macro CONV_RELU_EN clamps negative results to zero before serialisation.
module conv_stream_top #(
  parameter int DATA_W = 8,
  parameter int K      = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         keep_filter,
  conv_stream_if.slave s,
  output logic         busy,
  output logic         done
);
  localparam int N      = K*K;
  localparam int ACC_W  = 2*DATA_W + $clog2(N);
  localparam int NBEAT  = (ACC_W + DATA_W - 1) / DATA_W;
  localparam int EXT_W  = NBEAT*DATA_W;
  localparam int IDX_W  = $clog2(N);
  localparam int BEAT_W = $clog2(NBEAT);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N-1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEAT-1);

  typedef enum logic [2:0] {IDLE, LOAD_IFM, LOAD_FLT, MAC, OUT} state_t;
  state_t state_q, state_d;

  logic [N-1:0][DATA_W-1:0]     ifm_win, flt_win;
  logic [IDX_W-1:0]             idx;
  logic [BEAT_W-1:0]            beat;
  logic signed [ACC_W-1:0]      acc, res;
  logic signed [2*DATA_W-1:0]   prod;
  logic signed [EXT_W-1:0]      ext;
  logic [NBEAT-1:0][DATA_W-1:0] beats;
  logic flt_loaded, reuse;
  logic accept, ifm_xfer, flt_xfer, out_xfer, idx_last;

  // done is registered, so the FSM is already IDLE while it is high; that start is dropped
  assign accept   = (state_q == IDLE) && start && !done;
  assign ifm_xfer = s.ifm_valid && s.ifm_ready;
  assign flt_xfer = s.flt_valid && s.flt_ready;
  assign out_xfer = s.out_valid && s.out_ready;
  assign idx_last = (idx == LAST_IDX);
  assign prod     = $signed(ifm_win[idx]) * $signed(flt_win[idx]);

`ifdef CONV_RELU_EN
  assign res = acc[ACC_W-1] ? '0 : acc;
`else
  assign res = acc;
`endif
  assign ext   = EXT_W'(res);
  assign beats = ext;

  always_comb begin
    state_d     = state_q;
    busy        = (state_q != IDLE);
    s.ifm_ready = (state_q == LOAD_IFM);
    s.flt_ready = (state_q == LOAD_FLT);
    s.out_valid = (state_q == OUT);
    s.out_last  = 1'b0;
    s.out_data  = '0;
    case (state_q)
      IDLE:     if (accept) state_d = LOAD_IFM;
      LOAD_IFM: if (ifm_xfer && idx_last) state_d = reuse ? MAC : LOAD_FLT;
      LOAD_FLT: if (flt_xfer && idx_last) state_d = MAC;
      MAC:      if (idx_last) state_d = OUT;
      OUT: begin
        s.out_data = beats[beat];
        s.out_last = (beat == LAST_BEAT);
        if (out_xfer && s.out_last) state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx        <= '0;
      beat       <= '0;
      acc        <= '0;
      flt_loaded <= 1'b0;
      reuse      <= 1'b0;
      done       <= 1'b0;
      ifm_win    <= '0;
      flt_win    <= '0;
    end else begin
      state_q <= state_d;
      done    <= out_xfer && s.out_last;
      case (state_q)
        IDLE: if (accept) begin
          reuse <= keep_filter && flt_loaded;
          idx   <= '0;
          beat  <= '0;
        end
        LOAD_IFM: if (ifm_xfer) begin
          ifm_win[idx] <= s.ifm_data;
          idx          <= idx_last ? '0 : idx + IDX_W'(1);
          if (idx_last) acc <= '0;
        end
        // flag only sets on the final beat, so an aborted load never counts as complete
        LOAD_FLT: if (flt_xfer) begin
          flt_win[idx] <= s.flt_data;
          idx          <= idx_last ? '0 : idx + IDX_W'(1);
          if (idx_last) flt_loaded <= 1'b1;
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          idx <= idx_last ? '0 : idx + IDX_W'(1);
        end
        OUT: if (out_xfer) beat <= s.out_last ? '0 : beat + BEAT_W'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_stream_top.sv
// Randomised bench for conv_stream_top (K=3, DATA_W=8) against a dot-product reference model.
module tb_conv_stream_top;
  localparam int DW = 8, K = 3, N = K*K, NBEAT = 3, BUDGET = 2000;
  typedef logic signed [DW-1:0] win_t [N];

  logic clk, rst, start, keep_filter, busy, done;
  int   n_chk, n_err;
  bit   flt_loaded_m;
  win_t flt_m;

  conv_stream_if #(.DATA_W(DW)) bus();

  conv_stream_top #(.DATA_W(DW), .K(K)) dut (
    .clk(clk), .rst(rst), .start(start), .keep_filter(keep_filter),
    .s(bus), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_ifm_ready"}, bus.ifm_ready, 0);
    chk({pfx, "_flt_ready"}, bus.flt_ready, 0);
    chk({pfx, "_out_valid"}, bus.out_valid, 0);
    chk({pfx, "_out_data"},  bus.out_data,  0);
    chk({pfx, "_out_last"},  bus.out_last,  0);
    chk({pfx, "_busy"},      busy,          0);
    chk({pfx, "_done"},      done,          0);
  endtask

  // Entered and left on a negedge; returns on the negedge where done is seen.
  task automatic run_job(input win_t im, input win_t fm, input bit keep, input int vpct,
                         input int rpct, input bit stall, input int abort_at, input bit chk_lat);
    win_t use_f;
    bit reuse, hold;
    int ip, fp, nb, n0, last_x, done_at, rdy_cyc, stall_left, sum;
    logic [31:0]   usum;
    logic [DW-1:0] got [NBEAT];
    logic [DW-1:0] pd;
    logic          pl;
    reuse = keep && flt_loaded_m;
    if (reuse) use_f = flt_m; else use_f = fm;
    sum = 0;
    for (int i = 0; i < N; i++) sum += int'(im[i]) * int'(use_f[i]);
`ifdef CONV_RELU_EN
    if (sum < 0) sum = 0;
`endif
    usum = sum;
    ip = 0; fp = 0; nb = 0; n0 = -1; last_x = -1; done_at = -1; rdy_cyc = 0;
    stall_left = stall ? 5 : 0; hold = 0; pd = '0; pl = 0;
    for (int i = 0; i < NBEAT; i++) got[i] = '0;

    start = 1; keep_filter = keep;
    @(negedge clk);
    start = 0; keep_filter = 0;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      if (done) begin done_at = cyc; break; end
      if (abort_at >= 0 && fp == abort_at) begin
        rst = 0; bus.ifm_valid = 0; bus.flt_valid = 0; bus.out_ready = 0;
        #1 chk_reset_vals("abort");
        flt_loaded_m = 0;
        @(negedge clk); rst = 1;
        for (int w = 0; w < N; w++) begin
          @(negedge clk);
          if (done || bus.out_valid) chk("abort_no_output", 1, 0);
        end
        chk("abort_idle_busy", busy, 0);
        return;
      end
      if (bus.flt_ready) rdy_cyc++;
      bus.ifm_valid = (ip < N) && ($urandom_range(99) < vpct);
      if (ip < N) bus.ifm_data = im[ip]; else bus.ifm_data = DW'($urandom);
      if (bus.ifm_valid && bus.ifm_ready) begin if (ip == 0) n0 = cyc; ip++; end
      bus.flt_valid = (fp < N) && ($urandom_range(99) < vpct);
      if (fp < N) bus.flt_data = fm[fp]; else bus.flt_data = DW'($urandom);
      if (bus.flt_valid && bus.flt_ready) fp++;
      if (bus.out_valid && hold) begin
        chk("out_data_stable", bus.out_data, pd);
        chk("out_last_stable", bus.out_last, pl);
      end
      if (stall && nb == 1 && stall_left > 0 && bus.out_valid) begin
        bus.out_ready = 0; stall_left--;
      end else bus.out_ready = ($urandom_range(99) < rpct);
      if (bus.out_valid && bus.out_ready) begin
        if (nb < NBEAT) got[nb] = bus.out_data;
        chk("out_last", bus.out_last, nb == NBEAT-1);
        last_x = cyc; nb++;
      end
      hold = bus.out_valid && !bus.out_ready; pd = bus.out_data; pl = bus.out_last;
      @(negedge clk);
    end
    bus.ifm_valid = 0; bus.flt_valid = 0; bus.out_ready = 0;
    if (done_at < 0) begin chk("timeout", 1, 0); return; end
    for (int i = 0; i < NBEAT; i++) chk($sformatf("beat%0d", i), got[i], usum[DW*i +: DW]);
    chk("beat_count", nb, NBEAT);
    chk("done_after_last", done_at - last_x, 1);
    chk("busy_at_done", busy, 0);
    if (reuse) chk("flt_ready_on_reuse", rdy_cyc, 0);
    else       chk("flt_beats", fp, N);
    if (chk_lat && !reuse) chk("latency", done_at - n0, 3*N + NBEAT);
    if (!reuse) begin flt_loaded_m = 1; flt_m = fm; end
  endtask

  initial begin
    win_t a, b;
    int vp, rp;
    bit st;
    n_chk = 0; n_err = 0; flt_loaded_m = 0;
    rst = 0; start = 0; keep_filter = 0;
    bus.ifm_valid = 0; bus.ifm_data = '0; bus.flt_valid = 0; bus.flt_data = '0; bus.out_ready = 0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1;
    @(negedge clk);

    // ones x twos; keep_filter on the first job must still load the filter
    for (int i = 0; i < N; i++) begin a[i] = 8'sd1; b[i] = 8'sd2; end
    run_job(a, b, 1, 100, 100, 0, -1, 1);
    start = 1; keep_filter = 1;
    @(negedge clk);
    start = 0; keep_filter = 0;
    chk("start_with_done", busy, 0);
    chk("done_one_cycle", done, 0);

    // reuse stored filter of twos
    for (int i = 0; i < N; i++) begin a[i] = 8'sd3; b[i] = 8'sd0; end
    run_job(a, b, 1, 100, 100, 0, -1, 1);
    @(negedge clk);

    // most negative result, with back-pressure on beat 1
    for (int i = 0; i < N; i++) begin a[i] = -8'sd128; b[i] = 8'sd127; end
    run_job(a, b, 0, 100, 100, 1, -1, 0);
    @(negedge clk);

    // reset after 4 filter beats, then keep_filter must reload
    for (int i = 0; i < N; i++) begin a[i] = DW'($urandom); b[i] = DW'($urandom); end
    run_job(a, b, 0, 100, 100, 0, 4, 0);
    for (int i = 0; i < N; i++) begin a[i] = DW'($urandom); b[i] = DW'($urandom); end
    run_job(a, b, 1, 100, 100, 0, -1, 1);
    @(negedge clk);

    for (int j = 0; j < 30; j++) begin
      for (int i = 0; i < N; i++) begin
        a[i] = ($urandom_range(3) == 0) ? -8'sd128 : DW'($urandom);
        b[i] = ($urandom_range(3) == 0) ?  8'sd127 : DW'($urandom);
      end
      vp = ($urandom_range(2) == 0) ? 100 : $urandom_range(100, 40);
      rp = ($urandom_range(2) == 0) ? 100 : $urandom_range(100, 40);
      st = 1'($urandom_range(1));
      run_job(a, b, 1'($urandom_range(1)), vp, rp, st, -1, vp == 100 && rp == 100 && !st);
      repeat (1 + $urandom_range(2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
